mips_decode_unit: RTL and testbench

- Combined ID-stage core for a MIPS32 pipeline: instruction decoder, next-instruction-address calculator and a 32x32 register file in one block.
- Sits between fetch and the ID pipeline register.
- Decode, target calculation and register reads are combinational; only the register file is clocked.
- The enclosing ID stage registers all outputs and handles freeze and syscall bubbles.

---
 rtl/mips_decode_unit_pkg.sv | 99 +++++++++
 rtl/mips_decode_unit_regfile.sv | 30 +++
 rtl/mips_decode_unit.sv | 111 +++++++++++
 tb/tb_mips_decode_unit.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/mips_decode_unit_pkg.sv
// mips_decode_unit_pkg: opcodes, functs, ALU codes and control bundle shared by the decode unit
package mips_decode_unit_pkg;

    localparam logic [5:0] OP_SPECIAL = 6'h00;
    localparam logic [5:0] OP_REGIMM  = 6'h01;
    localparam logic [5:0] OP_J       = 6'h02;
    localparam logic [5:0] OP_JAL     = 6'h03;
    localparam logic [5:0] OP_BEQ     = 6'h04;
    localparam logic [5:0] OP_BNE     = 6'h05;
    localparam logic [5:0] OP_BLEZ    = 6'h06;
    localparam logic [5:0] OP_BGTZ    = 6'h07;
    localparam logic [5:0] OP_ADDI    = 6'h08;
    localparam logic [5:0] OP_ADDIU   = 6'h09;
    localparam logic [5:0] OP_SLTI    = 6'h0A;
    localparam logic [5:0] OP_SLTIU   = 6'h0B;
    localparam logic [5:0] OP_ANDI    = 6'h0C;
    localparam logic [5:0] OP_ORI     = 6'h0D;
    localparam logic [5:0] OP_XORI    = 6'h0E;
    localparam logic [5:0] OP_LUI     = 6'h0F;
    localparam logic [5:0] OP_LB      = 6'h20;
    localparam logic [5:0] OP_LH      = 6'h21;
    localparam logic [5:0] OP_LW      = 6'h23;
    localparam logic [5:0] OP_LBU     = 6'h24;
    localparam logic [5:0] OP_LHU     = 6'h25;
    localparam logic [5:0] OP_SB      = 6'h28;
    localparam logic [5:0] OP_SH      = 6'h29;
    localparam logic [5:0] OP_SW      = 6'h2B;
    localparam logic [5:0] OP_LL      = 6'h30;
    localparam logic [5:0] OP_SC      = 6'h38;

    localparam logic [5:0] FN_SLL     = 6'h00;
    localparam logic [5:0] FN_SRL     = 6'h02;
    localparam logic [5:0] FN_SRA     = 6'h03;
    localparam logic [5:0] FN_SLLV    = 6'h04;
    localparam logic [5:0] FN_SRLV    = 6'h06;
    localparam logic [5:0] FN_SRAV    = 6'h07;
    localparam logic [5:0] FN_JR      = 6'h08;
    localparam logic [5:0] FN_JALR    = 6'h09;
    localparam logic [5:0] FN_SYSCALL = 6'h0C;
    localparam logic [5:0] FN_ADD     = 6'h20;
    localparam logic [5:0] FN_ADDU    = 6'h21;
    localparam logic [5:0] FN_SUB     = 6'h22;
    localparam logic [5:0] FN_SUBU    = 6'h23;
    localparam logic [5:0] FN_AND     = 6'h24;
    localparam logic [5:0] FN_OR      = 6'h25;
    localparam logic [5:0] FN_XOR     = 6'h26;
    localparam logic [5:0] FN_NOR     = 6'h27;
    localparam logic [5:0] FN_SLT     = 6'h2A;
    localparam logic [5:0] FN_SLTU    = 6'h2B;

    localparam logic [4:0] RT_BLTZ    = 5'h00;
    localparam logic [4:0] RT_BGEZ    = 5'h01;
    localparam logic [4:0] RT_BLTZAL  = 5'h10;
    localparam logic [4:0] RT_BGEZAL  = 5'h11;

    localparam logic [5:0] ALU_NOP    = 6'h00;
    localparam logic [5:0] ALU_LUI    = 6'h0F;
    localparam logic [5:0] ALU_ADD    = 6'h20;
    localparam logic [5:0] ALU_ADDU   = 6'h21;
    localparam logic [5:0] ALU_SUBU   = 6'h23;
    localparam logic [5:0] ALU_AND    = 6'h24;
    localparam logic [5:0] ALU_OR     = 6'h25;
    localparam logic [5:0] ALU_XOR    = 6'h26;
    localparam logic [5:0] ALU_LL     = 6'h28;
    localparam logic [5:0] ALU_SLT    = 6'h2A;
    localparam logic [5:0] ALU_SLTU   = 6'h2B;
    localparam logic [5:0] ALU_SC     = 6'h36;

    localparam logic [4:0] REG_RA     = 5'd31;

    typedef struct packed {
        logic       link;
        logic       reg_dest;
        logic       jump;
        logic       branch;
        logic       mem_read;
        logic       mem_write;
        logic       alu_src;
        logic       reg_write;
        logic       jump_register;
        logic       sign_or_zero;
        logic       syscall;
        logic [5:0] alu_control;
    } ctrl_t;

    function automatic logic [5:0] imm_alu(input logic [5:0] op);
        case (op)
            OP_ADDI:  return ALU_ADD;
            OP_ADDIU: return ALU_ADDU;
            OP_SLTI:  return ALU_SLT;
            OP_SLTIU: return ALU_SLTU;
            OP_ANDI:  return ALU_AND;
            OP_ORI:   return ALU_OR;
            OP_XORI:  return ALU_XOR;
            default:  return ALU_LUI;
        endcase
    endfunction

endpackage

// File: rtl/mips_decode_unit_regfile.sv
// mips_regfile: 32-entry register file, r0 hardwired to zero, three read ports with write-through bypass
module mips_regfile #(
    parameter int NREGS  = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [4:0]        ra,
    input  logic [4:0]        rb,
    input  logic [4:0]        rc,
    input  logic [4:0]        wa,
    input  logic [DATA_W-1:0] wd,
    input  logic              we,
    output logic [DATA_W-1:0] da,
    output logic [DATA_W-1:0] db,
    output logic [DATA_W-1:0] dc
);
    logic [DATA_W-1:0] regs [NREGS];

    always_ff @(posedge CLK) begin
        if (RESET)
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        else if (we && wa != '0)
            regs[wa] <= wd;
    end

    assign da = ra == '0 ? '0 : (we && wa == ra) ? wd : regs[ra];
    assign db = rb == '0 ? '0 : (we && wa == rb) ? wd : regs[rb];
    assign dc = rc == '0 ? '0 : (we && wa == rc) ? wd : regs[rc];
endmodule

// File: rtl/mips_decode_unit.sv
// mips_decode_unit: MIPS32 ID-stage core combining decoder, next-address calculator and register file
module mips_decode_unit
    import mips_decode_unit_pkg::*;
#(
    parameter int NREGS  = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [DATA_W-1:0] Instr,
    input  logic [DATA_W-1:0] Instr_PC_Plus4,
    input  logic [4:0]        WriteReg,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              Write,
    output logic              Link,
    output logic              RegDest,
    output logic              Jump,
    output logic              Branch,
    output logic              MemRead,
    output logic              MemWrite,
    output logic              ALUSrc,
    output logic              RegWrite,
    output logic              JumpRegister,
    output logic              SignOrZero,
    output logic              Syscall,
    output logic [5:0]        ALUControl,
    output logic [4:0]        DestReg,
    output logic [DATA_W-1:0] DataA,
    output logic [DATA_W-1:0] DataB,
    output logic [DATA_W-1:0] DataC,
    output logic [DATA_W-1:0] NextInstructionAddress
);
    ctrl_t      c;
    logic [5:0] op, fn;
    logic [4:0] rs, rt, rd;

    assign op = Instr[31:26];
    assign rs = Instr[25:21];
    assign rt = Instr[20:16];
    assign rd = Instr[15:11];
    assign fn = Instr[5:0];

    always_comb begin
        c = '0;
        case (op)
            OP_SPECIAL:
                case (fn)
                    FN_SLL, FN_SRL, FN_SRA, FN_SLLV, FN_SRLV, FN_SRAV, FN_ADD, FN_ADDU,
                    FN_SUB, FN_SUBU, FN_AND, FN_OR, FN_XOR, FN_NOR, FN_SLT, FN_SLTU:
                        {c.reg_dest, c.reg_write, c.sign_or_zero, c.alu_control} = {3'b111, fn};
                    FN_JR:
                        {c.reg_dest, c.jump, c.jump_register, c.sign_or_zero, c.alu_control} = {4'b1111, fn};
                    FN_JALR:
                        {c.reg_dest, c.jump, c.jump_register, c.link, c.reg_write, c.sign_or_zero,
                         c.alu_control} = {6'b111111, fn};
                    FN_SYSCALL:
                        {c.syscall, c.alu_control} = {1'b1, fn};
                    default: ;
                endcase
            OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI, OP_LUI:
                {c.alu_src, c.reg_write, c.sign_or_zero, c.alu_control} =
                    {2'b11, !(op inside {OP_ANDI, OP_ORI, OP_XORI}), imm_alu(op)};
            OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW:
                {c.mem_read, c.reg_write, c.alu_src, c.sign_or_zero, c.alu_control} = {4'b1111, ALU_ADDU};
            OP_SB, OP_SH, OP_SW:
                {c.mem_write, c.alu_src, c.sign_or_zero, c.alu_control} = {3'b111, ALU_ADDU};
            OP_LL:
                {c.mem_read, c.reg_write, c.syscall, c.sign_or_zero, c.alu_control} = {4'b1111, ALU_LL};
            OP_SC:
                {c.mem_write, c.reg_write, c.syscall, c.sign_or_zero, c.alu_control} = {4'b1111, ALU_SC};
            OP_BEQ, OP_BNE, OP_BLEZ, OP_BGTZ:
                {c.branch, c.sign_or_zero, c.alu_control} = {2'b11, ALU_SUBU};
            OP_REGIMM:
                case (rt)
                    RT_BLTZ, RT_BGEZ:
                        {c.branch, c.sign_or_zero, c.alu_control} = {2'b11, ALU_SUBU};
                    RT_BLTZAL, RT_BGEZAL:
                        {c.branch, c.link, c.reg_write, c.sign_or_zero, c.alu_control} = {4'b1111, ALU_SUBU};
                    default: ;
                endcase
            OP_J:
                {c.jump, c.sign_or_zero, c.alu_control} = {2'b11, ALU_NOP};
            OP_JAL:
                {c.jump, c.link, c.reg_write, c.sign_or_zero, c.alu_control} = {4'b1111, ALU_NOP};
            default: ;
        endcase
    end

    assign {Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite,
            JumpRegister, SignOrZero, Syscall, ALUControl} = c;
    assign DestReg = c.reg_dest ? rd : (c.link ? REG_RA : rt);

    mips_regfile #(.NREGS(NREGS), .DATA_W(DATA_W)) u_regfile (
        .CLK   (CLK),
        .RESET (RESET),
        .ra    (rs),
        .rb    (rt),
        .rc    (DestReg),
        .wa    (WriteReg),
        .wd    (WriteData),
        .we    (Write),
        .da    (DataA),
        .db    (DataB),
        .dc    (DataC)
    );

    // Branch target is produced unconditionally; the EX stage decides whether it is taken
    assign NextInstructionAddress = (c.jump && c.jump_register) ? DataA :
                                    c.jump ? {Instr_PC_Plus4[DATA_W-1:DATA_W-4], Instr[25:0], 2'b00} :
                                    Instr_PC_Plus4 + {{(DATA_W-18){Instr[15]}}, Instr[15:0], 2'b00};
endmodule

// File: tb/tb_mips_decode_unit.sv
// tb_mips_decode_unit: scoreboard bench comparing the decode unit against a table-driven reference model
module tb_mips_decode_unit;
    logic        CLK, RESET, Write;
    logic [31:0] Instr, Instr_PC_Plus4, WriteData;
    logic [4:0]  WriteReg;
    logic        Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite;
    logic        JumpRegister, SignOrZero, Syscall;
    logic [5:0]  ALUControl;
    logic [4:0]  DestReg;
    logic [31:0] DataA, DataB, DataC, NextInstructionAddress;

    mips_decode_unit dut (
        .CLK                    (CLK),
        .RESET                  (RESET),
        .Instr                  (Instr),
        .Instr_PC_Plus4         (Instr_PC_Plus4),
        .WriteReg               (WriteReg),
        .WriteData              (WriteData),
        .Write                  (Write),
        .Link                   (Link),
        .RegDest                (RegDest),
        .Jump                   (Jump),
        .Branch                 (Branch),
        .MemRead                (MemRead),
        .MemWrite               (MemWrite),
        .ALUSrc                 (ALUSrc),
        .RegWrite               (RegWrite),
        .JumpRegister           (JumpRegister),
        .SignOrZero             (SignOrZero),
        .Syscall                (Syscall),
        .ALUControl             (ALUControl),
        .DestReg                (DestReg),
        .DataA                  (DataA),
        .DataB                  (DataB),
        .DataC                  (DataC),
        .NextInstructionAddress (NextInstructionAddress)
    );

    typedef struct {
        logic [16:0] ctrl;
        logic [4:0]  dest;
        logic [31:0] a, b, c, nia;
        int          id;
    } exp_t;

    exp_t        q[$];
    int          tests = 0;
    int          fails = 0;
    int          txn = 0;
    logic [31:0] mreg [32];
    logic [16:0] op_t [64];
    logic [16:0] fn_t [64];
    logic [16:0] ri_t [32];

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    // Control word built from flag letters: Link, regDest, Jump, Branch, memRead(R), Memwrite(M), Alusrc, reGwrite, jumP reg, Z=SignOrZero, Y=syscall
    function automatic logic [16:0] f(input string s, input logic [5:0] alu);
        string       k = "LDJBRMAGPZY";
        logic [10:0] m = '0;
        for (int i = 0; i < s.len(); i++)
            for (int j = 0; j < 11; j++)
                if (s[i] == k[j]) m[10-j] = 1'b1;
        return {m, alu};
    endfunction

    function automatic logic [16:0] model_ctrl(input logic [31:0] ins);
        return ins[31:26] == 6'h00 ? fn_t[ins[5:0]] :
               ins[31:26] == 6'h01 ? ri_t[ins[20:16]] : op_t[ins[31:26]];
    endfunction

    function automatic logic [31:0] model_read(input logic [4:0] a, input logic we, input logic [4:0] wr,
                                               input logic [31:0] wd);
        if (a == 0) return 32'h0;
        if (we && wr == a) return wd;
        return mreg[a];
    endfunction

    task automatic chk(input string name, input int id, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s txn %0d: got %h expected %h", name, id, act, exp);
        end
    endtask

    task automatic issue(input logic [31:0] ins, input logic [31:0] pc4, input logic we,
                         input logic [4:0] wr, input logic [31:0] wd, input logic rst);
        exp_t e;
        int   off;
        @(posedge CLK);
        #1;
        Instr = ins;
        Instr_PC_Plus4 = pc4;
        Write = we;
        WriteReg = wr;
        WriteData = wd;
        RESET = rst;
        e.ctrl = model_ctrl(ins);
        e.dest = e.ctrl[15] ? ins[15:11] : (e.ctrl[16] ? 5'd31 : ins[20:16]);
        e.a = model_read(ins[25:21], we, wr, wd);
        e.b = model_read(ins[20:16], we, wr, wd);
        e.c = model_read(e.dest, we, wr, wd);
        off = int'($signed(ins[15:0]));
        e.nia = (e.ctrl[14] && e.ctrl[8]) ? e.a :
                e.ctrl[14] ? {pc4[31:28], ins[25:0], 2'b00} : pc4 + 32'(off * 4);
        e.id = txn++;
        q.push_back(e);
        if (rst) foreach (mreg[i]) mreg[i] = 32'h0;
        else if (we && wr != 0) mreg[wr] = wd;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("ctrl", e.id, 32'({Link, RegDest, Jump, Branch, MemRead, MemWrite, ALUSrc, RegWrite,
                                       JumpRegister, SignOrZero, Syscall, ALUControl}), 32'(e.ctrl));
                chk("DestReg", e.id, 32'(DestReg), 32'(e.dest));
                chk("DataA", e.id, DataA, e.a);
                chk("DataB", e.id, DataB, e.b);
                chk("DataC", e.id, DataC, e.c);
                chk("NextAddr", e.id, NextInstructionAddress, e.nia);
            end
        end
    end

    initial begin
        logic [31:0] ins, wd, pc4;
        logic [4:0]  wr;
        logic        we, rst;
        int          sel;
        RESET = 1'b1;
        Write = 1'b0;
        Instr = '0;
        Instr_PC_Plus4 = '0;
        WriteReg = '0;
        WriteData = '0;
        foreach (mreg[i]) mreg[i] = 32'h0;
        foreach (op_t[i]) op_t[i] = '0;
        foreach (fn_t[i]) fn_t[i] = '0;
        foreach (ri_t[i]) ri_t[i] = '0;
        foreach (fn_t[i])
            if (i inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2A, 6'h2B})
                fn_t[i] = f("DGZ", 6'(i));
        fn_t[6'h08] = f("DJPZ", 6'h08);
        fn_t[6'h09] = f("DJPLGZ", 6'h09);
        fn_t[6'h0C] = f("Y", 6'h0C);
        op_t[6'h08] = f("AGZ", 6'h20);
        op_t[6'h09] = f("AGZ", 6'h21);
        op_t[6'h0A] = f("AGZ", 6'h2A);
        op_t[6'h0B] = f("AGZ", 6'h2B);
        op_t[6'h0C] = f("AG", 6'h24);
        op_t[6'h0D] = f("AG", 6'h25);
        op_t[6'h0E] = f("AG", 6'h26);
        op_t[6'h0F] = f("AGZ", 6'h0F);
        foreach (op_t[i]) if (i inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) op_t[i] = f("RGAZ", 6'h21);
        foreach (op_t[i]) if (i inside {6'h28, 6'h29, 6'h2B}) op_t[i] = f("MAZ", 6'h21);
        foreach (op_t[i]) if (i inside {[6'h04:6'h07]}) op_t[i] = f("BZ", 6'h23);
        op_t[6'h30] = f("RGYZ", 6'h28);
        op_t[6'h38] = f("MGYZ", 6'h36);
        op_t[6'h02] = f("JZ", 6'h00);
        op_t[6'h03] = f("JLGZ", 6'h00);
        ri_t[0]  = f("BZ", 6'h23);
        ri_t[1]  = f("BZ", 6'h23);
        ri_t[16] = f("BLGZ", 6'h23);
        ri_t[17] = f("BLGZ", 6'h23);

        issue(32'h0000_0000, 32'h0, 1'b0, 5'd0, 32'h0, 1'b1);
        issue(32'h00A0_0021, 32'h0, 1'b1, 5'd0, 32'hFFFF_FFFF, 1'b0);
        issue(32'h0000_0021, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        issue(32'h0100_0021, 32'h0, 1'b1, 5'd8, 32'h1234_5678, 1'b0);
        issue(32'h0100_0021, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);
        issue(32'h0022_1821, 32'h0040_0000, 1'b0, 5'd0, 32'h0, 1'b0);
        issue(32'h3404_8000, 32'h0040_0000, 1'b0, 5'd0, 32'h0, 1'b0);
        issue(32'h0C04_0000, 32'h0040_0004, 1'b0, 5'd0, 32'h0, 1'b0);
        issue(32'h0000_0000, 32'h0, 1'b1, 5'd31, 32'h0040_0010, 1'b0);
        issue(32'h03E0_0008, 32'h0040_0008, 1'b0, 5'd0, 32'h0, 1'b0);
        issue(32'h03E0_0008, 32'h0040_0008, 1'b1, 5'd31, 32'h00AB_CDE0, 1'b0);
        issue(32'h1000_FFFF, 32'h0040_0008, 1'b0, 5'd0, 32'h0, 1'b0);
        issue(32'h0000_000C, 32'h0040_0008, 1'b0, 5'd0, 32'h0, 1'b0);
        issue(32'hC000_0000, 32'h0040_0008, 1'b0, 5'd0, 32'h0, 1'b0);
        issue(32'hFC00_0000, 32'h0040_0008, 1'b0, 5'd0, 32'h0, 1'b0);
        issue(32'h0100_0021, 32'h0, 1'b1, 5'd8, 32'hDEAD_BEEF, 1'b1);
        issue(32'h0100_0021, 32'h0, 1'b0, 5'd0, 32'h0, 1'b0);

        for (int n = 0; n < 600; n++) begin
            ins = $urandom();
            sel = $urandom_range(0, 4);
            if (sel == 0) ins[31:26] = 6'h00;
            if (sel == 1) begin
                ins[31:26] = 6'h01;
                sel = $urandom_range(0, 4);
                ins[20:16] = sel == 0 ? 5'd0 : sel == 1 ? 5'd1 : sel == 2 ? 5'd16 : sel == 3 ? 5'd17 : ins[20:16];
            end
            we = 1'($urandom_range(0, 1));
            wr = $urandom_range(0, 3) == 0 ? ins[25:21] : 5'($urandom_range(0, 31));
            wd = $urandom();
            pc4 = $urandom();
            rst = $urandom_range(0, 63) == 0;
            issue(ins, pc4, we, wr, wd, rst);
        end

        for (int i = 0; i < 20 && q.size() != 0; i++) @(negedge CLK);
        #1;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: got %0d pending expected 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
